// File: rtl/lsu_mem_aligner.sv
// Load/store aligner between an LSU and a word-wide memory port. It shifts store data and
// byte enables into their lanes, and returns the load word shifted down to lane 0 without extension.
module lsu_mem_aligner #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [size-1:0] req_addr,
  input  logic [size-1:0] req_wdata,
  input  logic [2:0]      req_type,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [size-1:0] mem_addr,
  output logic [size-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_rvalid,
  input  logic [size-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [size-1:0] rsp_data,
  output logic [2:0]      rsp_type,
  output logic            rsp_err,
  output logic [1:0]      dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready, and a memory
  // command transfers where mem_valid && mem_ready. mem_valid and its payload stay stable until
  // the transfer. rsp_valid is a single-cycle pulse with no back-pressure.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic       cap_we;
  logic [1:0] cap_off;
  logic [2:0] cap_type;

  logic       accept;
  logic       req_illegal;
  logic [4:0] req_shamt;
  logic [4:0] cap_shamt;
  logic [3:0] store_be;

  assign req_ready = (state_q == IDLE);
  assign dbg_state = state_q;
  assign req_shamt = {req_addr[1:0], 3'b000};
  assign cap_shamt = {cap_off, 3'b000};

  // Undefined funct3 codes, a halfword on an odd address and a word off a word boundary are all rejected.
  always_comb begin
    req_illegal = 1'b0;
    case (req_type)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      3'b001, 3'b101:         req_illegal = req_addr[0];
      3'b010:                 req_illegal = (req_addr[1:0] != 2'b00);
      default:                req_illegal = 1'b0;
    endcase
  end

  always_comb begin
    store_be = 4'b1111;
    case (req_type[1:0])
      2'b00:   store_be = 4'b0001 << req_addr[1:0];
      2'b01:   store_be = 4'b0011 << req_addr[1:0];
      default: store_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_illegal ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_ready) state_d = cap_we ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_off   <= 2'b00;
      cap_type  <= 3'b000;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_type  <= 3'b000;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we   <= req_we;
        cap_off  <= req_addr[1:0];
        cap_type <= req_type;
        if (!req_illegal) begin
          mem_valid <= 1'b1;
          mem_we    <= req_we;
          mem_addr  <= {req_addr[size-1:2], 2'b00};
          mem_wdata <= req_wdata << req_shamt;
          mem_be    <= req_we ? store_be : 4'b1111;
        end
      end

      if (state_q == REQ && mem_ready) mem_valid <= 1'b0;

      rsp_valid <= (state_d == RESP);

      // Response fields change only when entering RESP, so they hold between completions.
      if (state_d == RESP && state_q != RESP) begin
        rsp_type <= accept ? req_type : cap_type;
        rsp_err  <= accept;
        rsp_data <= (state_q == WAIT) ? (mem_rdata >> cap_shamt) : '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_aligner.sv
// Directed bench for lsu_mem_aligner: each scenario steps cycle by cycle and compares against
// hand-computed values; a held-request run uses an expected queue fed from a small memory model.
module tb_lsu_mem_aligner;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_type;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_type;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  lsu_mem_aligner #(.size(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_type(rsp_type),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] typ);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_type  = typ;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] waddr);
    return {waddr[15:0] ^ 16'hC3A5, waddr[15:0]};
  endfunction

  task automatic illegal_case(input string tag, input logic [31:0] addr, input logic [2:0] typ);
    drive_req(1'b0, addr, 32'h0, typ);
    step();
    req_valid = 1'b0;
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_rsp_err"},   {31'b0, rsp_err},   32'd1);
    check({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'd0);
    check({tag, "_rsp_type"},  {29'b0, rsp_type},  {29'b0, typ});
    step();
    check({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int n_sent, n_rsp, n_hs, n_overlap;
    logic pend;
    logic [31:0] pend_addr, a;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_type = 3'b000; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_mem_be",    {28'b0, mem_be}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data,  32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // LBU 0x103, accepted on the first edge after reset release
    reset = 1'b1;
    mem_ready = 1'b1;
    drive_req(1'b0, 32'h0000_0103, 32'h0, 3'b100);
    step();
    req_valid = 1'b0;
    check("lbu_mem_valid", {31'b0, mem_valid}, 32'd1);
    check("lbu_mem_addr",  mem_addr, 32'h0000_0100);
    check("lbu_mem_be",    {28'b0, mem_be}, 32'hF);
    check("lbu_mem_we",    {31'b0, mem_we}, 32'd0);
    check("lbu_busy",      {31'b0, req_ready}, 32'd0);
    step();
    check("lbu_t2_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("lbu_t2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    step();
    mem_rvalid = 1'b0;
    check("lbu_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lbu_rsp_data",  rsp_data, 32'h0000_00AA);
    check("lbu_rsp_type",  {29'b0, rsp_type}, 32'd4);
    check("lbu_rsp_err",   {31'b0, rsp_err}, 32'd0);
    step();
    check("lbu_pulse_end", {31'b0, rsp_valid}, 32'd0);
    check("lbu_hold_data", rsp_data, 32'h0000_00AA);

    // SH 0x202
    drive_req(1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001);
    step();
    req_valid = 1'b0;
    check("sh_mem_wdata", mem_wdata, 32'hABCD_0000);
    check("sh_mem_be",    {28'b0, mem_be}, 32'hC);
    check("sh_mem_addr",  mem_addr, 32'h0000_0200);
    check("sh_mem_we",    {31'b0, mem_we}, 32'd1);
    step();
    check("sh_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("sh_rsp_err",   {31'b0, rsp_err}, 32'd0);
    check("sh_rsp_data",  rsp_data, 32'd0);
    check("sh_mem_valid", {31'b0, mem_valid}, 32'd0);
    step();

    // SB 0x101
    drive_req(1'b1, 32'h0000_0101, 32'h0000_00EE, 3'b000);
    step();
    req_valid = 1'b0;
    check("sb_mem_wdata", mem_wdata, 32'h0000_EE00);
    check("sb_mem_be",    {28'b0, mem_be}, 32'h2);
    step(); step();

    // Illegal requests
    illegal_case("lw_mis",  32'h0000_0301, 3'b010);
    illegal_case("type011", 32'h0000_0100, 3'b011);
    illegal_case("hu_mis",  32'h0000_0103, 3'b101);

    // LH 0x400 with mem_ready low for three cycles
    mem_ready = 1'b0;
    drive_req(1'b0, 32'h0000_0400, 32'h0, 3'b001);
    step();
    req_valid = 1'b0;
    check("lh_valid_c1", {31'b0, mem_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lh_valid_held", {31'b0, mem_valid}, 32'd1);
      check("lh_addr_held",  mem_addr, 32'h0000_0400);
      check("lh_be_held",    {28'b0, mem_be}, 32'hF);
      if (i == 2) mem_ready = 1'b1;
    end
    step();
    check("lh_after_hs_valid", {31'b0, mem_valid}, 32'd0);
    step();
    check("lh_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_6666;
    step();
    mem_rvalid = 1'b0;
    check("lh_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lh_rsp_data",  rsp_data, 32'h5555_6666);
    step();

    // LHU 0x102: upper halfword moved to lane 0, not extended
    drive_req(1'b0, 32'h0000_0102, 32'h0, 3'b101);
    step();
    req_valid = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    step();
    mem_rvalid = 1'b0;
    check("lhu_rsp_data", rsp_data, 32'h0000_80FF);
    check("lhu_rsp_type", {29'b0, rsp_type}, 32'd5);
    step();

    // Reset while waiting for read data, then a stray rvalid
    drive_req(1'b0, 32'h0000_0500, 32'h0, 3'b010);
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    check("rstw_mem_addr",  mem_addr, 32'd0);
    check("rstw_rsp_data",  rsp_data, 32'd0);
    step();
    check("rstw_still_idle", {31'b0, rsp_valid}, 32'd0);

    // req_valid held high across three LBU loads; memory answers one cycle after each handshake
    n_sent = 0; n_rsp = 0; n_hs = 0; n_overlap = 0; pend = 1'b0; pend_addr = '0;
    mem_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_rsp < 3; cyc++) begin
      mem_rvalid = pend;
      mem_rdata  = pend ? model_word(pend_addr) : 32'h0;
      pend       = mem_valid && mem_ready;
      pend_addr  = mem_addr;
      if (mem_valid && mem_ready) n_hs++;
      if (mem_valid && rsp_valid) n_overlap++;
      if (rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) check("b2b_unexpected_rsp", rsp_data, 32'hFFFF_FFFF);
        else check("b2b_rsp_data", rsp_data, exp_q.pop_front());
      end
      if (req_ready && n_sent < 3) begin
        a = 32'h0000_0600 + n_sent * 5;
        drive_req(1'b0, a, 32'h0, 3'b100);
        exp_q.push_back(model_word({a[31:2], 2'b00}) >> (8 * a[1:0]));
        n_sent++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0; mem_rvalid = 1'b0;
    check("b2b_rsp_count", n_rsp, 32'd3);
    check("b2b_accesses",  n_hs, 32'd3);
    check("b2b_queue_empty", exp_q.size(), 32'd0);
    check("b2b_no_overlap", n_overlap, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
